// File: rtl/rcas_pkg.sv
// Shared definitions for the chunked ripple-carry add/subtract sequencer.
// Holds the operation select codes, the slice width and the FSM state encoding.
package rcas_pkg;

  localparam logic RCAS_SEL_ADD = 1'b0;
  localparam logic RCAS_SEL_SUB = 1'b1;

  localparam int RCAS_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rcas_state_t;

endpackage

// File: rtl/rcas_8bit.sv
// Combinational 8-bit ripple-carry adder/subtractor slice.
// Subtraction inverts b; the caller supplies c_in=1 on the first chunk.
module rcas_8bit
  import rcas_pkg::*;
(
  input  logic [RCAS_CHUNK-1:0] a,
  input  logic [RCAS_CHUNK-1:0] b,
  input  logic                  sel,
  input  logic                  c_in,
  output logic [RCAS_CHUNK-1:0] sum,
  output logic                  c_out
);

  logic [RCAS_CHUNK-1:0] b_eff;
  logic                  carry;

  assign b_eff = b ^ {RCAS_CHUNK{sel}};

  always_comb begin
    sum   = '0;
    carry = c_in;
    for (int i = 0; i < RCAS_CHUNK; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ carry;
      carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/rcas_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer: one byte per clock through a shared 8-bit
// slice, LSB first, with the inter-chunk carry held in a register.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// RUN   | processing chunk idx, 0..NCHUNK-1
// DONE  | result held, rsp_valid=1 until rsp_ready
module rcas_seq_ctrl
  import rcas_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf
);

  localparam int NCHUNK = WIDTH / RCAS_CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  rcas_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic [IDX_W+2:0]      bit_off;
  logic [RCAS_CHUNK-1:0] slice_a, slice_b, slice_sum;
  logic                  slice_cin, slice_cout;

  // Byte offset is idx*8, built by concatenation to avoid a multiplier.
  assign bit_off   = {idx_q, 3'b000};
  assign slice_a   = a_q[bit_off +: RCAS_CHUNK];
  assign slice_b   = b_q[bit_off +: RCAS_CHUNK];
  assign slice_cin = (idx_q == '0) ? sel_q : carry_q;

  rcas_8bit u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .sel   (sel_q),
    .c_in  (slice_cin),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= RCAS_SEL_ADD;
      carry_q     <= 1'b0;
      result_q    <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    carry_d     = carry_q;
    result_d    = result_q;
    rsp_carry_d = rsp_carry_q;
    rsp_ovf_d   = rsp_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = RUN;
          a_d      = req_a;
          b_d      = req_b;
          sel_d    = req_sel;
          idx_d    = '0;
          carry_d  = 1'b0;
          result_d = '0;
        end
      end
      RUN: begin
        result_d[bit_off +: RCAS_CHUNK] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          idx_d       = '0;
          rsp_carry_d = slice_cout;
          // Signed overflow: operands agree in sign (b after inversion) but the
          // freshly computed MSB differs from A's sign.
          rsp_ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sel_q)) &&
                        (slice_sum[RCAS_CHUNK-1] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_ovf    = rsp_ovf_q;

endmodule
